// File: rtl/rf_alu_dm_seq.sv
// Multi-cycle LEGv8-style execution slice: register file, ALU and data memory
// sequenced through READ/EXEC/MEM/WB with a start/busy/done handshake.
module rf_alu_dm_seq #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DM_AW  = 8,
  parameter int unsigned IMM_W  = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [REG_AW-1:0] Read1,
  input  logic [REG_AW-1:0] Read2,
  input  logic [REG_AW-1:0] WriteReg,
  input  logic [1:0]        ALUOp,
  input  logic [10:0]       OpCodefield,
  input  logic [1:0]        AluSrc,
  input  logic [IMM_W-1:0]  SEin,
  input  logic              RegWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] Result,
  output logic              Zero
);

  localparam int unsigned NREG = 2 ** REG_AW;
  localparam int unsigned NDM  = 2 ** DM_AW;
  localparam logic [REG_AW-1:0] XZR = '1;

  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_MEM, S_WB} state_t;

  state_t r_state;
  state_t w_next;
  logic   w_capture;

  // Operation fields captured on the accepted start edge
  logic [REG_AW-1:0] r_rd1, r_rd2, r_wr_reg;
  logic [1:0]        r_aluop, r_src;
  logic [10:0]       r_opc;
  logic [IMM_W-1:0]  r_se;
  logic              r_reg_wr, r_mem_rd, r_mem_wr;

  logic [DATA_W-1:0] r_rf [NREG];
  logic [DATA_W-1:0] r_dm [NDM];
  logic [DATA_W-1:0] r_a, r_b, r_alu, r_result;
  logic              r_zero, r_busy, r_done;

  logic [DATA_W-1:0] w_rf_a, w_rf_b, w_opb, w_alu;
  logic [DM_AW-1:0]  w_dm_idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next    = S_READ;
          w_capture = 1'b1;
        end
      end
      S_READ:  w_next = S_EXEC;
      S_EXEC:  w_next = (r_mem_rd || r_mem_wr) ? S_MEM : S_WB;
      S_MEM:   w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_rf_a   = (r_rd1 == XZR) ? '0 : r_rf[r_rd1];
  assign w_rf_b   = (r_rd2 == XZR) ? '0 : r_rf[r_rd2];
  assign w_dm_idx = r_alu[DM_AW+2:3];

  // Operand B select and ALU function
  always_comb begin
    w_opb = r_b;
    case (r_src)
      2'b01:   w_opb = {{(DATA_W-IMM_W){r_se[IMM_W-1]}}, r_se};
      2'b10:   w_opb = DATA_W'(r_se);
      default: w_opb = r_b;
    endcase
    w_alu = r_a + w_opb;
    case (r_aluop)
      2'b01: w_alu = w_opb;
      2'b10: begin
        case (r_opc)
          OPC_SUB: w_alu = r_a - w_opb;
          OPC_AND: w_alu = r_a & w_opb;
          OPC_ORR: w_alu = r_a | w_opb;
          OPC_ADD: w_alu = r_a + w_opb;
          default: w_alu = r_a + w_opb;
        endcase
      end
      default: w_alu = r_a + w_opb;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd1    <= '0;
      r_rd2    <= '0;
      r_wr_reg <= '0;
      r_aluop  <= '0;
      r_src    <= '0;
      r_opc    <= '0;
      r_se     <= '0;
      r_reg_wr <= 1'b0;
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_alu    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= (w_next == S_WB);
      if (w_capture) begin
        r_rd1    <= Read1;
        r_rd2    <= Read2;
        r_wr_reg <= WriteReg;
        r_aluop  <= ALUOp;
        r_src    <= AluSrc;
        r_opc    <= OpCodefield;
        r_se     <= SEin;
        r_reg_wr <= RegWrite;
        r_mem_rd <= MemRead;
        r_mem_wr <= MemWrite;
      end
      if (r_state == S_READ) begin
        r_a <= w_rf_a;
        r_b <= w_rf_b;
      end
      if (r_state == S_EXEC) begin
        r_alu    <= w_alu;
        r_zero   <= (w_alu == '0);
        r_result <= w_alu;
      end
      if (r_state == S_MEM && r_mem_rd) r_result <= r_dm[w_dm_idx];
    end
  end

  // Register file: cleared on reset, written on the edge leaving WB
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rf <= '{default: '0};
    end else if (r_state == S_WB && r_reg_wr && r_wr_reg != XZR) begin
      r_rf[r_wr_reg] <= r_result;
    end
  end

  // Data memory is not reset; a load in the same op suppresses the store
  always_ff @(posedge clock) begin
    if (r_state == S_MEM && r_mem_wr && !r_mem_rd) r_dm[w_dm_idx] <= r_b;
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign Result = r_result;
  assign Zero   = r_zero;

endmodule

// File: tb/tb_rf_alu_dm_seq.sv
// Directed and randomized checks of rf_alu_dm_seq against an array-based
// architectural model of the register file and data memory.
module tb_rf_alu_dm_seq;

  logic        clock, reset, start;
  logic [4:0]  Read1, Read2, WriteReg;
  logic [1:0]  ALUOp, AluSrc;
  logic [10:0] OpCodefield;
  logic [8:0]  SEin;
  logic        RegWrite, MemRead, MemWrite;
  logic        busy, done, Zero;
  logic [63:0] Result;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [63:0] m_rf [32];
  logic [63:0] m_dm [256];
  bit          m_dv [256];

  localparam logic [10:0] ADD = 11'b10001011000;
  localparam logic [10:0] SUB = 11'b11001011000;
  localparam logic [10:0] AND = 11'b10001010000;
  localparam logic [10:0] ORR = 11'b10101010000;

  rf_alu_dm_seq dut (
    .clock(clock), .reset(reset), .start(start),
    .Read1(Read1), .Read2(Read2), .WriteReg(WriteReg),
    .ALUOp(ALUOp), .OpCodefield(OpCodefield), .AluSrc(AluSrc), .SEin(SEin),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .busy(busy), .done(done), .Result(Result), .Zero(Zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rd(input logic [4:0] r);
    return (r == 5'd31) ? 64'd0 : m_rf[r];
  endfunction

  function automatic logic [63:0] alu_model(input logic [1:0] aluop, input logic [10:0] opc,
                                            input logic [1:0] src, input logic [8:0] se,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [63:0] bv;
    if (src == 2'b01)      bv = 64'($signed(se));
    else if (src == 2'b10) bv = 64'(se);
    else                   bv = b;
    if (aluop == 2'b01) return bv;
    if (aluop == 2'b10) begin
      if (opc == SUB) return a - bv;
      if (opc == AND) return a & bv;
      if (opc == ORR) return a | bv;
    end
    return a + bv;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 64'd0;
  endtask

  // Launch one op from an idle, post-edge point and check latency/outputs.
  // glitch: pulse start with other operands mid-op and again in WB.
  task automatic run_op(input string tag, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] wr, input logic [1:0] aluop, input logic [10:0] opc,
                        input logic [1:0] src, input logic [8:0] se,
                        input bit regw, input bit memr, input bit memw, input bit glitch);
    logic [63:0] a, b, alu, res;
    int lat, n;
    a   = rd(r1);
    b   = rd(r2);
    alu = alu_model(aluop, opc, src, se, a, b);
    res = memr ? m_dm[alu[10:3]] : alu;
    lat = (memr || memw) ? 4 : 3;
    Read1 = r1; Read2 = r2; WriteReg = wr; ALUOp = aluop; OpCodefield = opc;
    AluSrc = src; SEin = se; RegWrite = regw; MemRead = memr; MemWrite = memw;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    n = 1;
    while (!done && n < 8) begin
      if (glitch && n == 1) begin
        start = 1'b1; Read1 = 5'd1; SEin = ~se; AluSrc = 2'b10; ALUOp = 2'b00;
      end
      @(posedge clock); #1;
      start = 1'b0;
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_res"}, Result, res);
    check({tag, "_zero"}, 64'(Zero), 64'(alu == 64'd0));
    if (glitch) start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
    if (memw && !memr) begin
      m_dm[alu[10:3]] = b;
      m_dv[alu[10:3]] = 1'b1;
    end
    if (regw && wr != 5'd31) m_rf[wr] = res;
  endtask

  initial begin
    logic [4:0]  r1, r2, wr;
    logic [1:0]  aluop, src;
    logic [10:0] opc;
    logic [8:0]  se;
    bit          regw, memr, memw;
    logic [63:0] alu;

    start = 0; Read1 = 0; Read2 = 0; WriteReg = 0; ALUOp = 0; OpCodefield = 0;
    AluSrc = 0; SEin = 0; RegWrite = 0; MemRead = 0; MemWrite = 0;
    for (int i = 0; i < 256; i++) begin m_dm[i] = 64'd0; m_dv[i] = 1'b0; end

    // T1: reset holds outputs low
    reset = 1'b1;
    model_reset();
    repeat (3) begin
      @(posedge clock); #1;
      check("rst_bd", {62'd0, busy, done}, 64'd0);
    end
    check("rst_res", Result, 64'd0);
    check("rst_zero", 64'(Zero), 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    run_op("t1_add", 5'd0, 5'd1, 5'd2, 2'b10, ADD, 2'b00, 9'd0, 1, 0, 0, 0);
    check("t1_const", {63'd0, Zero}, 64'd1);

    // T2: immediates
    run_op("t2_addi5", 5'd31, 5'd0, 5'd1, 2'b00, 11'd0, 2'b01, 9'd5, 1, 0, 0, 0);
    check("t2_c5", Result, 64'd5);
    run_op("t2_neg", 5'd31, 5'd0, 5'd2, 2'b00, 11'd0, 2'b01, 9'h1FD, 1, 0, 0, 0);
    check("t2_cneg", Result, 64'hFFFF_FFFF_FFFF_FFFD);

    // T3: SUB and ORR
    run_op("t3_sub", 5'd1, 5'd1, 5'd3, 2'b10, SUB, 2'b00, 9'd0, 1, 0, 0, 0);
    check("t3_csub", {Result[62:0], Zero}, 64'd1);
    run_op("t3_orr", 5'd1, 5'd2, 5'd3, 2'b10, ORR, 2'b00, 9'd0, 1, 0, 0, 0);
    check("t3_corr", Result, 64'hFFFF_FFFF_FFFF_FFFD);

    // T4: store, unaligned load, forwarding through RF
    run_op("t4_stur", 5'd31, 5'd1, 5'd0, 2'b00, 11'd0, 2'b01, 9'd16, 0, 0, 1, 0);
    run_op("t4_ldur", 5'd31, 5'd0, 5'd4, 2'b00, 11'd0, 2'b01, 9'd19, 1, 1, 0, 0);
    check("t4_cld", Result, 64'd5);
    run_op("t4_add", 5'd4, 5'd31, 5'd5, 2'b10, ADD, 2'b00, 9'd0, 1, 0, 0, 0);
    check("t4_cadd", Result, 64'd5);
    run_op("t4_both", 5'd31, 5'd2, 5'd6, 2'b00, 11'd0, 2'b01, 9'd16, 1, 1, 1, 0);
    check("t4_cboth", Result, 64'd5);

    // T5: XZR writes dropped; stray start pulses ignored
    run_op("t5_xzr", 5'd31, 5'd0, 5'd31, 2'b00, 11'd0, 2'b01, 9'd7, 1, 0, 0, 0);
    check("t5_c7", Result, 64'd7);
    run_op("t5_rdx", 5'd31, 5'd31, 5'd8, 2'b10, ADD, 2'b00, 9'd0, 1, 0, 0, 0);
    check("t5_c0", Result, 64'd0);
    run_op("t5_glitch", 5'd31, 5'd0, 5'd9, 2'b00, 11'd0, 2'b01, 9'd3, 1, 0, 0, 1);
    check("t5_c3", Result, 64'd3);

    // T6: reset during EXEC discards the op and clears the RF
    Read1 = 5'd31; WriteReg = 5'd6; ALUOp = 2'b00; AluSrc = 2'b01; SEin = 9'd9;
    RegWrite = 1; MemRead = 0; MemWrite = 0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check("t6_bd", {62'd0, busy, done}, 64'd0);
    check("t6_res", {Result[62:0], Zero}, 64'd0);
    model_reset();
    repeat (2) begin
      @(posedge clock); #1;
      check("t6_nodone", 64'(done), 64'd0);
    end
    reset = 1'b0;
    @(posedge clock); #1;
    run_op("t6_add", 5'd6, 5'd31, 5'd7, 2'b10, ADD, 2'b00, 9'd0, 1, 0, 0, 0);
    check("t6_c0", Result, 64'd0);

    // Randomized ops
    for (int k = 0; k < 60; k++) begin
      r1 = 5'($urandom_range(0, 31));
      r2 = 5'($urandom_range(0, 31));
      wr = 5'($urandom_range(0, 31));
      se = 9'($urandom);
      opc = 11'($urandom);
      regw = 1; memr = 0; memw = 0;
      case ($urandom_range(0, 4))
        0: begin
          aluop = 2'b10; src = 2'b00;
          case ($urandom_range(0, 4))
            0: opc = ADD; 1: opc = SUB; 2: opc = AND; 3: opc = ORR; default: ;
          endcase
        end
        1: begin aluop = 2'($urandom_range(0, 3)); src = 2'($urandom_range(1, 3)); end
        2: begin aluop = 2'b00; src = 2'b10; r1 = 5'd31; se = 9'($urandom_range(0, 255)); memr = 1; end
        3: begin aluop = 2'b00; src = 2'b10; r1 = 5'd31; se = 9'($urandom_range(0, 255));
                 memw = 1; regw = bit'($urandom_range(0, 1)); end
        default: begin aluop = 2'b01; src = 2'b00; regw = 0; end
      endcase
      alu = alu_model(aluop, opc, src, se, rd(r1), rd(r2));
      if (memr && !m_dv[alu[10:3]]) begin memr = 0; memw = 1; end
      run_op("rnd", r1, r2, wr, aluop, opc, src, se, regw, memr, memw, bit'($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
